dac_ctrl: RTL and testbench

Dual-channel serial DAC sequencer. It takes CPU-written sample pairs through the I/O register bus and buffers them in a 4-entry FIFO. At a programmable sample rate it shifts each pair out MSB-first on two data lines with a shared bit clock and latch strobe. Its outputs are routed to PB4–PB7 (DAT1, DAT0, LE, CLK) through the GPIO special-function mux.

---
 rtl/dac_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_dac_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_ctrl.sv
// Dual-channel serial DAC sequencer: register bus, 4x16 sample FIFO, frame timer, bit shifter.
// Define DAC_CTRL_IRQ_EN to build the CTRL.IRQEN bit and the FIFO low-water interrupt.
module dac_ctrl (
    input  logic       wb_clk_i,
    input  logic       rst,
    input  logic [3:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic       bus_cyc,
    input  logic       bus_we,
    output logic       irq,
    output logic       dac_clk,
    output logic       dac_dat0,
    output logic       dac_dat1,
    output logic       dac_le
);

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

    logic        en_q;
    logic [7:0]  clkdiv_q;
    logic [7:0]  data_a_q;
    logic [7:0]  data_b_q;
    logic [15:0] rate_q;
    logic        ovf_q, unf_q;
    logic [7:0]  data_out_q;
    logic [15:0] timer_q, timer_d;

    logic [15:0] fifo_q [4];
    logic [1:0]  wptr_q, rptr_q;
    logic [2:0]  count_q, count_d;

    state_t      state_q;
    logic [7:0]  ph_q;
    logic [2:0]  bit_q;
    logic [6:0]  sh_a_q, sh_b_q;
    logic        clk_q, dat0_q, dat1_q, le_q;

    logic        wr_en, flush, tick, idle, empty, full;
    logic        pop, push_req, push_ok, ovf_set, unf_set, ph_done, irqen_rd;
    logic [15:0] head;
    logic [7:0]  rdata;

    assign wr_en    = bus_cyc & bus_we;
    assign flush    = wr_en & (addr == 4'd0) & data_in[7];
    assign tick     = en_q & (timer_q == 16'd0);
    assign idle     = (state_q == IDLE);
    assign empty    = (count_q == 3'd0);
    assign full     = (count_q == 3'd4);
    assign head     = fifo_q[rptr_q];
    assign pop      = tick & idle & ~empty;
    assign push_req = wr_en & (addr == 4'd3);
    // A pop in the same cycle frees the slot, so a push to a full FIFO is still taken.
    assign push_ok  = push_req & (~full | pop);
    assign ovf_set  = push_req & full & ~pop;
    assign unf_set  = tick & idle & empty;
    assign ph_done  = (ph_q == clkdiv_q);

`ifdef DAC_CTRL_IRQ_EN
    logic irqen_q;

    always_ff @(posedge wb_clk_i or posedge rst) begin
        if (rst)
            irqen_q <= 1'b0;
        else if (wr_en && addr == 4'd0)
            irqen_q <= data_in[1];
    end

    assign irqen_rd = irqen_q;
    assign irq      = irqen_q & (count_q < 3'd2);
`else
    assign irqen_rd = 1'b0;
    assign irq      = 1'b0;
`endif

    always_comb begin
        rdata = 8'hAA;
        case (addr)
            4'd0: rdata = {6'b0, irqen_rd, en_q};
            4'd1: rdata = clkdiv_q;
            4'd2: rdata = data_a_q;
            4'd3: rdata = data_b_q;
            4'd4: rdata = rate_q[7:0];
            4'd5: rdata = rate_q[15:8];
            4'd6: rdata = {~idle, count_q, unf_q, ovf_q, full, empty};
            default: rdata = 8'hAA;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge rst) begin
        if (rst) begin
            en_q       <= 1'b0;
            clkdiv_q   <= 8'd0;
            data_a_q   <= 8'd0;
            data_b_q   <= 8'd0;
            rate_q     <= 16'hFFFF;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            data_out_q <= 8'd0;
        end else begin
            if (wr_en) begin
                case (addr)
                    4'd0: en_q           <= data_in[0];
                    4'd1: clkdiv_q       <= data_in;
                    4'd2: data_a_q       <= data_in;
                    4'd3: data_b_q       <= data_in;
                    4'd4: rate_q[7:0]    <= data_in;
                    4'd5: rate_q[15:8]   <= data_in;
                    default: ;
                endcase
            end
            if (ovf_set)
                ovf_q <= 1'b1;
            else if (wr_en && addr == 4'd6 && data_in[2])
                ovf_q <= 1'b0;
            if (unf_set)
                unf_q <= 1'b1;
            else if (wr_en && addr == 4'd6 && data_in[3])
                unf_q <= 1'b0;
            if (bus_cyc)
                data_out_q <= rdata;
        end
    end

    // RATE is only sampled at reload, so writes mid-period do not disturb the current frame slot.
    always_comb begin
        timer_d = timer_q - 16'd1;
        if (!en_q || timer_q == 16'd0)
            timer_d = rate_q;
    end

    always_ff @(posedge wb_clk_i or posedge rst) begin
        if (rst)
            timer_q <= 16'hFFFF;
        else
            timer_q <= timer_d;
    end

    always_comb begin
        count_d = count_q + {2'b0, push_ok} - {2'b0, pop};
        if (flush)
            count_d = 3'd0;
    end

    always_ff @(posedge wb_clk_i or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++)
                fifo_q[i] <= 16'd0;
            wptr_q  <= 2'd0;
            rptr_q  <= 2'd0;
            count_q <= 3'd0;
        end else begin
            count_q <= count_d;
            if (flush) begin
                wptr_q <= 2'd0;
                rptr_q <= 2'd0;
            end else begin
                if (push_ok) begin
                    fifo_q[wptr_q] <= {data_a_q, data_in};
                    wptr_q         <= wptr_q + 2'd1;
                end
                if (pop)
                    rptr_q <= rptr_q + 2'd1;
            end
        end
    end

    // Shift registers hold only the bits not yet on the wire; the MSB lives in dat0_q/dat1_q.
    always_ff @(posedge wb_clk_i or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ph_q    <= 8'd0;
            bit_q   <= 3'd0;
            sh_a_q  <= 7'd0;
            sh_b_q  <= 7'd0;
            clk_q   <= 1'b0;
            dat0_q  <= 1'b0;
            dat1_q  <= 1'b0;
            le_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q <= SHIFT_LO;
                        ph_q    <= 8'd0;
                        bit_q   <= 3'd7;
                        sh_a_q  <= head[14:8];
                        sh_b_q  <= head[6:0];
                        dat0_q  <= head[15];
                        dat1_q  <= head[7];
                        clk_q   <= 1'b0;
                    end
                end
                SHIFT_LO: begin
                    if (ph_done) begin
                        state_q <= SHIFT_HI;
                        ph_q    <= 8'd0;
                        clk_q   <= 1'b1;
                    end else
                        ph_q <= ph_q + 8'd1;
                end
                SHIFT_HI: begin
                    if (ph_done) begin
                        ph_q   <= 8'd0;
                        clk_q  <= 1'b0;
                        sh_a_q <= {sh_a_q[5:0], 1'b0};
                        sh_b_q <= {sh_b_q[5:0], 1'b0};
                        if (bit_q == 3'd0) begin
                            state_q <= LATCH;
                            le_q    <= 1'b1;
                            dat0_q  <= 1'b0;
                            dat1_q  <= 1'b0;
                        end else begin
                            state_q <= SHIFT_LO;
                            bit_q   <= bit_q - 3'd1;
                            dat0_q  <= sh_a_q[6];
                            dat1_q  <= sh_b_q[6];
                        end
                    end else
                        ph_q <= ph_q + 8'd1;
                end
                LATCH: begin
                    if (ph_done) begin
                        state_q <= IDLE;
                        ph_q    <= 8'd0;
                        le_q    <= 1'b0;
                    end else
                        ph_q <= ph_q + 8'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out = data_out_q;
    assign dac_clk  = clk_q;
    assign dac_dat0 = dat0_q;
    assign dac_dat1 = dat1_q;
    assign dac_le   = le_q;

endmodule

// File: tb/tb_dac_ctrl.sv
// Scoreboard bench for dac_ctrl: pushed sample pairs are queued and matched against frames
// reassembled from the serial lines; timing of phases and ticks is measured alongside.
module tb_dac_ctrl;

    logic       wb_clk_i = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] addr = 4'd0;
    logic [7:0] data_in = 8'd0;
    logic [7:0] data_out;
    logic       bus_cyc = 1'b0;
    logic       bus_we = 1'b0;
    logic       irq, dac_clk, dac_dat0, dac_dat1, dac_le;

    int total = 0;
    int bad = 0;

    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    int          spans[$];
    int          rises[$];
    int          m_hi = 0, m_le = 0;

    dac_ctrl dut (
        .wb_clk_i(wb_clk_i), .rst(rst), .addr(addr), .data_in(data_in),
        .data_out(data_out), .bus_cyc(bus_cyc), .bus_we(bus_we), .irq(irq),
        .dac_clk(dac_clk), .dac_dat0(dac_dat0), .dac_dat1(dac_dat1), .dac_le(dac_le)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Serial monitor: rebuilds each frame from dat0/dat1 at dac_clk rises.
    int         cyc = 0, nbits = 0, rise0 = 0, hicnt = 0, lecnt = 0;
    logic       p_clk = 1'b0, p_le = 1'b0;
    logic [7:0] ma = 8'd0, mb = 8'd0;

    always @(negedge wb_clk_i) begin
        cyc++;
        if (rst) begin
            p_clk = 1'b0; p_le = 1'b0; nbits = 0; hicnt = 0; lecnt = 0;
        end else begin
            if (dac_clk && !p_clk) begin
                ma = {ma[6:0], dac_dat0};
                mb = {mb[6:0], dac_dat1};
                nbits++;
                if (nbits == 1) rise0 = cyc;
                hicnt = 0;
            end
            if (dac_clk) hicnt++;
            else if (p_clk) m_hi = hicnt;
            if (dac_le) lecnt++;
            if (dac_le && !p_le) obs_q.push_back({ma, mb});
            if (!dac_le && p_le) begin
                m_le = lecnt; lecnt = 0;
                spans.push_back(cyc - rise0);
                rises.push_back(rise0);
                nbits = 0;
            end
            p_clk = dac_clk; p_le = dac_le;
        end
    end

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        addr = a; data_in = d; bus_cyc = 1'b1; bus_we = 1'b1;
        @(negedge wb_clk_i);
        bus_cyc = 1'b0; bus_we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        addr = a; bus_cyc = 1'b1; bus_we = 1'b0;
        @(negedge wb_clk_i);
        bus_cyc = 1'b0;
        d = data_out;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input bit ok);
        wr(4'd2, a);
        wr(4'd3, b);
        if (ok) exp_q.push_back({a, b});
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (spans.size() < n && k < budget) begin
            @(negedge wb_clk_i);
            k++;
        end
    endtask

    task automatic wait_clk_high(input int budget);
        int k = 0;
        while (!dac_clk && k < budget) begin
            @(negedge wb_clk_i);
            k++;
        end
    endtask

    task automatic clear_mon();
        obs_q.delete(); spans.delete(); rises.delete();
    endtask

    task automatic test_reset();
        logic [3:0] ra[7] = '{4'd6, 4'd4, 4'd5, 4'd0, 4'd1, 4'd2, 4'd15};
        logic [7:0] re[7] = '{8'h01, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hAA};
        logic [7:0] v;
        repeat (2) @(negedge wb_clk_i);
        total++;
        if ({dac_clk, dac_dat0, dac_dat1, dac_le, irq, data_out} !== 13'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=0", {dac_clk, dac_dat0, dac_dat1, dac_le, irq, data_out});
        end
        rst = 1'b0;
        @(negedge wb_clk_i);
        for (int i = 0; i < 7; i++) begin
            rd(ra[i], v);
            total++;
            if (v !== re[i]) begin
                bad++;
                $display("FAIL reset_reg%0d got=%h exp=%h", ra[i], v, re[i]);
            end
        end
    endtask

    task automatic test_single_frame();
        logic [15:0] got, ex;
        clear_mon();
        wr(4'd1, 8'd0); wr(4'd4, 8'd99); wr(4'd5, 8'd0);
        push(8'hA5, 8'h3C, 1'b1);
        push(8'h5A, 8'hC3, 1'b1);
        wr(4'd0, 8'h01);
        wait_frames(2, 400);
        total++;
        if (spans.size() < 2) begin
            bad++;
            $display("FAIL single_timeout got=%0d exp=2 frames", spans.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                got = obs_q.pop_front(); ex = exp_q.pop_front();
                total++;
                if (got !== ex) begin
                    bad++;
                    $display("FAIL single_data%0d got=%h exp=%h", i, got, ex);
                end
            end
            total++;
            if (spans[0] != 16) begin
                bad++;
                $display("FAIL single_frame_len got=%0d exp=17", spans[0] + 1);
            end
            total++;
            if (m_le != 1 || m_hi != 1) begin
                bad++;
                $display("FAIL single_le_hi got=%0d/%0d exp=1/1", m_le, m_hi);
            end
            total++;
            if (rises[1] - rises[0] != 100) begin
                bad++;
                $display("FAIL single_tick_period got=%0d exp=100", rises[1] - rises[0]);
            end
        end
        wr(4'd0, 8'h00); wr(4'd6, 8'h0C);
        total++;
        if ({dac_clk, dac_dat0, dac_dat1, dac_le} !== 4'd0) begin
            bad++;
            $display("FAIL single_idle_lines got=%b exp=0000", {dac_clk, dac_dat0, dac_dat1, dac_le});
        end
    endtask

    task automatic test_divider();
        logic [15:0] got, ex;
        clear_mon();
        wr(4'd1, 8'd3);
        push(8'hA5, 8'h3C, 1'b1);
        wr(4'd0, 8'h01);
        wait_frames(1, 400);
        total++;
        if (spans.size() < 1) begin
            bad++;
            $display("FAIL div_timeout got=%0d exp=1 frame", spans.size());
        end else begin
            got = obs_q.pop_front(); ex = exp_q.pop_front();
            total++;
            if (got !== ex) begin
                bad++;
                $display("FAIL div_data got=%h exp=%h", got, ex);
            end
            total++;
            if (spans[0] != 64) begin
                bad++;
                $display("FAIL div_frame_len got=%0d exp=68", spans[0] + 4);
            end
            total++;
            if (m_le != 4 || m_hi != 4) begin
                bad++;
                $display("FAIL div_le_hi got=%0d/%0d exp=4/4", m_le, m_hi);
            end
        end
        wr(4'd0, 8'h00); wr(4'd6, 8'h0C); wr(4'd1, 8'd0);
    endtask

    task automatic test_overflow();
        logic [7:0]  v;
        logic [15:0] got, ex;
        clear_mon();
        for (int i = 0; i < 5; i++)
            push(8'h10 + 8'(i), 8'h80 + 8'(i), i < 4);
        rd(4'd6, v);
        total++;
        if (v !== 8'h46) begin bad++; $display("FAIL ovf_status got=%h exp=46", v); end
        wr(4'd6, 8'h04);
        rd(4'd6, v);
        total++;
        if (v !== 8'h42) begin bad++; $display("FAIL ovf_clear got=%h exp=42", v); end
        wr(4'd4, 8'd40); wr(4'd5, 8'd0);
        wr(4'd0, 8'h01);
        // The DATA_B write of this push lands on the tick/pop edge.
        repeat (39) @(negedge wb_clk_i);
        push(8'hEE, 8'h77, 1'b1);
        rd(4'd6, v);
        total++;
        if (v !== 8'hC2) begin bad++; $display("FAIL push_on_pop got=%h exp=C2", v); end
        wr(4'd0, 8'h00);
        wait_frames(1, 200);
        total++;
        if (obs_q.size() < 1) begin
            bad++;
            $display("FAIL ovf_frame_timeout got=%0d exp=1 frame", obs_q.size());
        end else begin
            got = obs_q.pop_front(); ex = exp_q.pop_front();
            total++;
            if (got !== ex) begin bad++; $display("FAIL ovf_frame got=%h exp=%h", got, ex); end
        end
        wr(4'd0, 8'h80);
        rd(4'd6, v);
        total++;
        if (v !== 8'h01) begin bad++; $display("FAIL flush_status got=%h exp=01", v); end
        exp_q.delete();
    endtask

    task automatic test_underrun();
        logic [7:0] v;
        clear_mon();
        wr(4'd4, 8'd9); wr(4'd5, 8'd0);
        wr(4'd0, 8'h01);
        repeat (9) @(negedge wb_clk_i);
        rd(4'd6, v);
        total++;
        if (v !== 8'h01) begin bad++; $display("FAIL unf_early got=%h exp=01", v); end
        rd(4'd6, v);
        total++;
        if (v !== 8'h09) begin bad++; $display("FAIL unf_set got=%h exp=09", v); end
        total++;
        if ({dac_clk, dac_dat0, dac_dat1, dac_le} !== 4'd0 || obs_q.size() != 0) begin
            bad++;
            $display("FAIL unf_lines got=%b exp=0000", {dac_clk, dac_dat0, dac_dat1, dac_le});
        end
        wr(4'd0, 8'h00); wr(4'd6, 8'h08);
        rd(4'd6, v);
        total++;
        if (v !== 8'h01) begin bad++; $display("FAIL unf_clear got=%h exp=01", v); end
    endtask

`ifdef DAC_CTRL_IRQ_EN
    task automatic test_irq();
        logic [7:0]  v;
        logic [15:0] got, ex;
        clear_mon();
        wr(4'd4, 8'd29); wr(4'd5, 8'd0);
        push(8'h01, 8'h02, 1'b1); push(8'h03, 8'h04, 1'b1); push(8'h05, 8'h06, 1'b1);
        wr(4'd0, 8'h02);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_count3 got=%b exp=0", irq); end
        wr(4'd0, 8'h03);
        wait_frames(2, 300);
        total++;
        if (spans.size() < 2) begin
            bad++;
            $display("FAIL irq_timeout got=%0d exp=2 frames", spans.size());
        end else begin
            total++;
            if (irq !== 1'b1) begin bad++; $display("FAIL irq_low_water got=%b exp=1", irq); end
            for (int i = 0; i < 2; i++) begin
                got = obs_q.pop_front(); ex = exp_q.pop_front();
                total++;
                if (got !== ex) begin bad++; $display("FAIL irq_data%0d got=%h exp=%h", i, got, ex); end
            end
        end
        push(8'h07, 8'h08, 1'b1); push(8'h09, 8'h0A, 1'b1);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_refill got=%b exp=0", irq); end
        wait_clk_high(100);
        wr(4'd0, 8'h82);
        rd(4'd6, v);
        total++;
        if (v !== 8'h81 || irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_flush got=%h/%b exp=81/1", v, irq);
        end
        wait_frames(3, 200);
        total++;
        if (obs_q.size() < 1) begin
            bad++;
            $display("FAIL irq_flush_frame_timeout got=%0d exp=1 frame", obs_q.size());
        end else begin
            got = obs_q.pop_front(); ex = exp_q.pop_front();
            total++;
            if (got !== ex) begin bad++; $display("FAIL irq_flush_frame got=%h exp=%h", got, ex); end
        end
        exp_q.delete();
        wr(4'd0, 8'h00);
    endtask
`else
    task automatic test_irq();
        logic [7:0] v;
        push(8'h11, 8'h22, 1'b0);
        wr(4'd0, 8'h02);
        rd(4'd0, v);
        total++;
        if (v !== 8'h00 || irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_disabled got=%h/%b exp=00/0", v, irq);
        end
        wr(4'd0, 8'h80);
    endtask
`endif

    task automatic test_reset_mid_frame();
        logic [7:0] v;
        clear_mon();
        wr(4'd4, 8'd20); wr(4'd5, 8'd0); wr(4'd1, 8'd1);
        push(8'hC3, 8'h5A, 1'b0);
        wr(4'd0, 8'h01);
        wait_clk_high(200);
        total++;
        if (dac_clk !== 1'b1) begin bad++; $display("FAIL rst_mid_no_shift got=%b exp=1", dac_clk); end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({dac_clk, dac_dat0, dac_dat1, dac_le, irq, data_out} !== 13'd0) begin
            bad++;
            $display("FAIL rst_mid_outputs got=%b exp=0", {dac_clk, dac_dat0, dac_dat1, dac_le, irq, data_out});
        end
        @(negedge wb_clk_i);
        rst = 1'b0;
        rd(4'd6, v);
        total++;
        if (v !== 8'h01) begin bad++; $display("FAIL rst_mid_status got=%h exp=01", v); end
        rd(4'd4, v);
        total++;
        if (v !== 8'hFF) begin bad++; $display("FAIL rst_mid_rate_l got=%h exp=FF", v); end
        rd(4'd5, v);
        total++;
        if (v !== 8'hFF) begin bad++; $display("FAIL rst_mid_rate_h got=%h exp=FF", v); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_divider();
        test_overflow();
        test_underrun();
        test_irq();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
